gshare_bpu: RTL
===============

// Module: gshare_bpu
// PURPOSE
//  Parametrised gshare branch prediction unit: replaces the fixed 8-bit predictor in the fetch/EX path.
//  Adds a tagged BTB (target + type), speculative global history with checkpoint recovery, mispredict
//  detection/redirect, and saturating stat counters. Fetch queries it every cycle; EX/MEM resolves.
// PARAMETERS
//  XLEN        32   PC / target width
//  GHR_W       8    global history bits; PHT has 2**GHR_W 2-bit counters
//  BTB_IDX_W   4    BTB index bits; 2**BTB_IDX_W direct-mapped entries
//  TAG_W       8    BTB tag bits, taken from pc[BTB_IDX_W+2 +: TAG_W]
//  STAT_W      32   stat counter width
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       asynchronous, active-low reset
//  f_valid        in   1       fetch lookup this cycle
//  f_pc           in   XLEN    fetch PC
//  pred_taken     out  1       predicted taken (combinational from f_pc, tables, GHR)
//  pred_target    out  XLEN    BTB target if pred_taken, else f_pc+4
//  pred_ghr       out  GHR_W   GHR before this lookup's shift; pipelined with the instruction
//  u_valid        in   1       resolved control-transfer instruction in EX/MEM
//  u_pc           in   XLEN    its PC
//  u_is_cond      in   1       conditional branch (opcode 1100011)
//  u_is_jump      in   1       jal/jalr (1101111/1100111); mutually exclusive with u_is_cond
//  u_taken        in   1       actual outcome (1 for jumps)
//  u_target       in   XLEN    actual target
//  u_pred_taken   in   1       pred_taken carried down the pipe
//  u_pred_target  in   XLEN    pred_target carried down the pipe
//  u_ghr          in   GHR_W   pred_ghr carried down the pipe
//  mispredict     out  1       combinational: flush + redirect this cycle
//  redirect_pc    out  XLEN    u_taken ? u_target : u_pc+4
//  stat_branches  out  STAT_W  resolved u_valid count
//  stat_mispred   out  STAT_W  mispredict count
// BEHAVIOUR
//  Reset (rst=0, async): GHR=0; every PHT counter=2'b01 (weak not-taken); all BTB valid=0;
//   stats=0. Outputs follow: pred_taken=0, pred_target=f_pc+4, mispredict=0.
//  Lookup (0-cycle): pidx=f_pc[GHR_W+1:2]^GHR; bidx=f_pc[BTB_IDX_W+1:2]; hit=valid[bidx]&&tag match.
//   pred_taken = f_valid && hit && (type==JUMP || pht[pidx][1]). Without f_valid: pred_taken=0.
//  Speculative GHR: f_valid && hit && type==COND -> GHR <= {GHR[GHR_W-2:0], pred_taken} next edge.
//  mispredict = u_valid && ((u_pred_taken!=u_taken) || (u_taken && u_pred_target!=u_target)).
//  Recovery: mispredict && u_is_cond -> GHR <= {u_ghr[GHR_W-2:0], u_taken};
//   mispredict && u_is_jump -> GHR <= u_ghr. Recovery wins over a same-cycle speculative shift.
//  PHT update (u_valid && u_is_cond): index u_pc[GHR_W+1:2]^u_ghr; +1 if taken, -1 if not,
//   saturating at 3 and 0. Jumps never touch PHT or GHR.
//  BTB update: u_valid && u_taken -> entry[u_pc idx] <= {valid=1, tag, u_target, type}; overwrites
//   any occupant. Not-taken cond branch never allocates or invalidates.
//  Write/read same cycle to same PHT/BTB entry: lookup sees OLD value; new visible next cycle.
//  Stats: +1 per u_valid / per mispredict; saturate at all-ones, never wrap.
//  Width rules: PC arithmetic modulo 2**XLEN (f_pc+4 wraps silently); pc[1:0] ignored.
//  Reset asserted mid-operation clears everything regardless of pending update.
// STRUCTURE
//  Package bpu_pkg: BTB type enum {BTB_COND=1'b0, BTB_JUMP=1'b1}, counter constants CNT_SNT=0,
//   CNT_WNT=1, CNT_WT=2, CNT_ST=3, BTB entry struct {valid, tag, target, type}.
//  Sub-module bpu_btb: tag/target/type arrays, combinational lookup port, one write port.
//  PHT, GHR, stats and mispredict logic in this module.
// TESTING
//  1 Reset, f_pc=0x100 f_valid=1 -> pred_taken=0, pred_target=0x104, stats=0.
//  2 Cond branch @0x200 tgt 0x180 resolved taken twice (u_ghr=0) -> BTB hit, counter 01->10->11;
//    next lookup with GHR=0 -> pred_taken=1, pred_target=0x180.
//  3 jal @0x300 tgt 0x400 resolved once -> lookup 0x300 pred_taken=1 independent of PHT; GHR unchanged.
//  4 GHR=8'hA5 speculative; update u_ghr=8'h0F cond not-taken with u_pred_taken=1 same cycle
//    as hitting lookup -> mispredict=1, redirect_pc=u_pc+4, next GHR=8'h1E.
//  5 Taken, direction correct, u_pred_target=0x180 vs u_target=0x1C0 -> mispredict=1,
//    redirect_pc=0x1C0, BTB target becomes 0x1C0.
//  6 STAT_W=4, 20 mispredicts -> stat_mispred holds 4'hF; rst=0 mid-burst -> all state cleared.

Source files
------------

// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared types and constants for the gshare branch prediction unit
package bpu_pkg;

    typedef enum logic {
        BTB_COND = 1'b0,
        BTB_JUMP = 1'b1
    } btb_type_e;

    localparam logic [1:0] CNT_SNT = 2'd0;
    localparam logic [1:0] CNT_WNT = 2'd1;
    localparam logic [1:0] CNT_WT  = 2'd2;
    localparam logic [1:0] CNT_ST  = 2'd3;

    localparam int BPU_XLEN  = 32;
    localparam int BPU_TAG_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [BPU_TAG_W-1:0] tag;
        logic [BPU_XLEN-1:0]  target;
        btb_type_e            btype;
    } btb_entry_t;

    function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        else
            return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/bpu_btb.sv
// rtl/bpu_btb.sv - direct-mapped tagged BTB, combinational lookup, single write port
module bpu_btb
    import bpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IDX_W = 4,
    parameter int TAG_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rd_pc,
    output logic            rd_hit,
    output logic [XLEN-1:0] rd_target,
    output btb_type_e       rd_type,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [XLEN-1:0] wr_target,
    input  btb_type_e       wr_type
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    btb_type_e          type_q   [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;

    assign rd_idx = rd_pc[IDX_W+1:2];
    assign rd_tag = rd_pc[IDX_W+2 +: TAG_W];
    assign wr_idx = wr_pc[IDX_W+1:2];
    assign wr_tag = wr_pc[IDX_W+2 +: TAG_W];

    // Reads see pre-write contents; a same-cycle write lands at the edge.
    assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_target = target_q[rd_idx];
    assign rd_type   = type_q[rd_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            valid_q <= '0;
        else if (wr_en)
            valid_q[wr_idx] <= 1'b1;
    end

    // Payload needs no reset: valid gates every use of it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
            type_q[wr_idx]   <= wr_type;
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, rd_pc[1:0], rd_pc[XLEN-1:IDX_W+2+TAG_W],
                              wr_pc[1:0], wr_pc[XLEN-1:IDX_W+2+TAG_W]};

endmodule

// File: rtl/gshare_bpu.sv
// rtl/gshare_bpu.sv - gshare predictor with BTB, speculative GHR recovery and stats
module gshare_bpu
    import bpu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int GHR_W     = 8,
    parameter int BTB_IDX_W = 4,
    parameter int TAG_W     = 8,
    parameter int STAT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_valid,
    input  logic [XLEN-1:0]   f_pc,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    output logic [GHR_W-1:0]  pred_ghr,
    input  logic              u_valid,
    input  logic [XLEN-1:0]   u_pc,
    input  logic              u_is_cond,
    input  logic              u_is_jump,
    input  logic              u_taken,
    input  logic [XLEN-1:0]   u_target,
    input  logic              u_pred_taken,
    input  logic [XLEN-1:0]   u_pred_target,
    input  logic [GHR_W-1:0]  u_ghr,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int PHT_N = 1 << GHR_W;

    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;
    logic [1:0]       pht_q [PHT_N];

    logic             btb_hit;
    logic [XLEN-1:0]  btb_target;
    btb_type_e        btb_type;
    logic [GHR_W-1:0] f_pidx;
    logic [GHR_W-1:0] u_pidx;
    logic             spec_shift;

    bpu_btb #(
        .XLEN  (XLEN),
        .IDX_W (BTB_IDX_W),
        .TAG_W (TAG_W)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_pc     (f_pc),
        .rd_hit    (btb_hit),
        .rd_target (btb_target),
        .rd_type   (btb_type),
        .wr_en     (u_valid && u_taken),
        .wr_pc     (u_pc),
        .wr_target (u_target),
        .wr_type   (u_is_jump ? BTB_JUMP : BTB_COND)
    );

    assign f_pidx = f_pc[GHR_W+1:2] ^ ghr_q;
    assign u_pidx = u_pc[GHR_W+1:2] ^ u_ghr;

    assign pred_taken  = f_valid && btb_hit && ((btb_type == BTB_JUMP) || pht_q[f_pidx][1]);
    assign pred_target = pred_taken ? btb_target : f_pc + XLEN'(4);
    assign pred_ghr    = ghr_q;
    assign spec_shift  = f_valid && btb_hit && (btb_type == BTB_COND);

    assign mispredict  = u_valid && ((u_pred_taken != u_taken) ||
                                     (u_taken && (u_pred_target != u_target)));
    assign redirect_pc = u_taken ? u_target : u_pc + XLEN'(4);

    // Resolution repairs history from the checkpoint and beats any speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (mispredict && u_is_cond)
            ghr_d = {u_ghr[GHR_W-2:0], u_taken};
        else if (mispredict && u_is_jump)
            ghr_d = u_ghr;
        else if (spec_shift)
            ghr_d = {ghr_q[GHR_W-2:0], pred_taken};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ghr_q <= '0;
        else
            ghr_q <= ghr_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHT_N; i++)
                pht_q[i] <= CNT_WNT;
        end else if (u_valid && u_is_cond) begin
            pht_q[u_pidx] <= cnt_update(pht_q[u_pidx], u_taken);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (u_valid && (stat_branches != '1))
                stat_branches <= stat_branches + STAT_W'(1);
            if (mispredict && (stat_mispred != '1))
                stat_mispred <= stat_mispred + STAT_W'(1);
        end
    end

endmodule
